// File: rtl/thro_ramp_sched_pkg.sv
// thro_pkg: shared types and constants for the throttle ramp scheduler.
//   thro_state_t  : FSM state encoding (3 bits, exposed on state_o)
//   THRO_MAX_VAL  : saturation level for the received target when clamping is built in
//   NUM_MOTORS    : number of staggered motor enables
//   clamp_target  : saturate a received throttle value to THRO_MAX_VAL
//   ramp_toward   : move a value toward a goal by at most one step, no overshoot
package thro_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_STAGGER  = 3'd1,
        ST_RUN      = 3'd2,
        ST_FAILSAFE = 3'd3
    } thro_state_t;

    localparam int THRO_MAX_VAL = 40;
    localparam int NUM_MOTORS   = 4;

    function automatic logic [7:0] clamp_target(input logic [7:0] v);
        return (v > 8'(THRO_MAX_VAL)) ? 8'(THRO_MAX_VAL) : v;
    endfunction

    // Done 9 bits wide so cur+step can never wrap past 255 before the
    // comparison against the goal picks the smaller move.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                               input logic [7:0] goal,
                                               input logic [8:0] step);
        logic [8:0] c9;
        logic [8:0] g9;
        logic [8:0] r9;
        c9 = {1'b0, cur};
        g9 = {1'b0, goal};
        r9 = c9;
        if (g9 > c9) begin
            r9 = ((g9 - c9) > step) ? (c9 + step) : g9;
        end else if (c9 > g9) begin
            r9 = ((c9 - g9) > step) ? (c9 - step) : g9;
        end
        return 8'(r9);
    endfunction

endpackage

// File: rtl/thro_tick_gen.sv
// thro_tick_gen: ramp prescaler. Counts 0..RAMP_DIV-1 and raises tick for
// the one cycle in which the count wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : single-cycle pulse every RAMP_DIV cycles
module thro_tick_gen #(
    parameter int RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = $clog2(RAMP_DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/thro_ramp_sched.sv
// thro_ramp_sched: arming / staggered motor enable / throttle ramp / link-loss
// failsafe controller in front of the per-motor offset generator.
//   clk, rst_n      : clock, asynchronous active-low reset
//   thro_rec_val    : received throttle target
//   thro_rec_valid  : single-cycle strobe, thro_rec_val is new
//   arm_req         : pilot arm switch (level)
//   disarm_req      : forced disarm (level)
//   thro_cmd        : rate-limited throttle command
//   thro_cmd_valid  : single-cycle strobe, thro_cmd has just changed
//   motor_en        : per-motor enable, bit0 = motor 1
//   armed           : state is RUN or FAILSAFE
//   failsafe        : state is FAILSAFE
//   state_o         : FSM state encoding (debug)
// Build option: define THRO_CLAMP_EN to saturate the loaded target to
// THRO_MAX_VAL and refuse arming progress on any over-range strobe.
//
// Strobe semantics: there is no back-pressure. thro_rec_valid is sampled on
// every clock edge and each high cycle is one new value; thro_cmd_valid is
// high in exactly the cycles where thro_cmd holds a value different from the
// previous cycle (it rises together with the new thro_cmd).
module thro_ramp_sched
    import thro_pkg::*;
#(
    parameter int RAMP_DIV     = 1000,
    parameter int STEP         = 1,
    parameter int ARM_THRO_MAX = 2,
    parameter int ARM_HOLD     = 50,
    parameter int STAGGER      = 10,
    parameter int LINK_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] thro_rec_val,
    input  logic       thro_rec_valid,
    input  logic       arm_req,
    input  logic       disarm_req,
    output logic [7:0] thro_cmd,
    output logic       thro_cmd_valid,
    output logic [3:0] motor_en,
    output logic       armed,
    output logic       failsafe,
    output logic [2:0] state_o
);

    thro_state_t           state, state_nxt;
    logic                  tick;
    logic [15:0]           hold_cnt, hold_nxt;
    logic [15:0]           stag_cnt, stag_nxt;
    logic [15:0]           link_cnt;
    logic [7:0]            target, load_val, cmd_nxt;
    logic [NUM_MOTORS-1:0] motor_nxt;
    logic                  link_lost, kill, arm_ok;

    thro_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef THRO_CLAMP_EN
    assign load_val = clamp_target(thro_rec_val);
`else
    assign load_val = thro_rec_val;
`endif

    // A fresh strobe wins over the tick increment, so a value arriving on a
    // tick cycle still restarts the timeout window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target   <= '0;
            link_cnt <= '0;
        end else if (thro_rec_valid) begin
            target   <= load_val;
            link_cnt <= '0;
        end else if (tick && (link_cnt < 16'(LINK_TIMEOUT))) begin
            link_cnt <= link_cnt + 16'd1;
        end
    end

    assign link_lost = (link_cnt >= 16'(LINK_TIMEOUT));
    assign kill      = disarm_req || !arm_req;

`ifdef THRO_CLAMP_EN
    assign arm_ok = arm_req && !disarm_req && (target <= 8'(ARM_THRO_MAX)) && !link_lost
                    && !(thro_rec_valid && (thro_rec_val > 8'(THRO_MAX_VAL)));
`else
    assign arm_ok = arm_req && !disarm_req && (target <= 8'(ARM_THRO_MAX)) && !link_lost;
`endif

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stag_nxt  = stag_cnt;
        motor_nxt = motor_en;
        cmd_nxt   = thro_cmd;
        case (state)
            ST_DISARMED: begin
                motor_nxt = '0;
                cmd_nxt   = '0;
                stag_nxt  = '0;
                if (!arm_ok) begin
                    hold_nxt = '0;
                end else if (tick) begin
                    if (hold_cnt >= 16'(ARM_HOLD - 1)) begin
                        state_nxt = ST_STAGGER;
                        hold_nxt  = '0;
                        motor_nxt = NUM_MOTORS'(1);
                    end else begin
                        hold_nxt = hold_cnt + 16'd1;
                    end
                end
            end
            ST_STAGGER: begin
                cmd_nxt = '0;
                // Kill is checked before timeout so a simultaneous disarm
                // never lands in FAILSAFE.
                if (kill) begin
                    state_nxt = ST_DISARMED;
                    motor_nxt = '0;
                end else if (link_lost) begin
                    state_nxt = ST_FAILSAFE;
                end else if (tick) begin
                    if (&motor_en) begin
                        state_nxt = ST_RUN;
                    end else if (stag_cnt >= 16'(STAGGER - 1)) begin
                        motor_nxt = {motor_en[NUM_MOTORS-2:0], 1'b1};
                        stag_nxt  = '0;
                    end else begin
                        stag_nxt = stag_cnt + 16'd1;
                    end
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_nxt = ST_DISARMED;
                    motor_nxt = '0;
                    cmd_nxt   = '0;
                end else if (link_lost) begin
                    state_nxt = ST_FAILSAFE;
                end else if (tick) begin
                    cmd_nxt = ramp_toward(thro_cmd, target, 9'(STEP));
                end
            end
            ST_FAILSAFE: begin
                if (thro_cmd == 8'd0) begin
                    state_nxt = ST_DISARMED;
                    motor_nxt = '0;
                end else if (tick) begin
                    cmd_nxt = ramp_toward(thro_cmd, 8'd0, 9'(STEP));
                end
            end
            default: begin
                state_nxt = ST_DISARMED;
                motor_nxt = '0;
                cmd_nxt   = '0;
                hold_nxt  = '0;
                stag_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_DISARMED;
            hold_cnt       <= '0;
            stag_cnt       <= '0;
            motor_en       <= '0;
            thro_cmd       <= '0;
            thro_cmd_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_nxt;
            stag_cnt       <= stag_nxt;
            motor_en       <= motor_nxt;
            thro_cmd       <= cmd_nxt;
            thro_cmd_valid <= (cmd_nxt != thro_cmd);
        end
    end

    assign armed    = (state == ST_RUN) || (state == ST_FAILSAFE);
    assign failsafe = (state == ST_FAILSAFE);
    assign state_o  = state;

endmodule
